// File: rtl/wb_timer_pkg.sv
// Register map, bit positions and decode width shared by the RTL and the firmware header.
package wb_timer_pkg;
  localparam int ADR_LSB = 2;
  localparam int ADR_W   = 3;

  localparam logic [ADR_W-1:0] REG_CTRL     = 3'd0;
  localparam logic [ADR_W-1:0] REG_STATUS   = 3'd1;
  localparam logic [ADR_W-1:0] REG_RELOAD   = 3'd2;
  localparam logic [ADR_W-1:0] REG_COUNT    = 3'd3;
  localparam logic [ADR_W-1:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_W     = 3;
  localparam int STATUS_EXP = 0;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction
endpackage

// File: rtl/wb_timer_presc.sv
// Prescaler: counts 0..div while enabled and emits a one-cycle tick on the wrap cycle.
module wb_timer_presc #(
  parameter int W = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         en,
  input  logic [W-1:0] div,
  input  logic         restart,
  output logic         tick
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  // >= so a divisor rewritten below the running count wraps immediately
  assign wrap = (cnt_q >= div);
  assign tick = en & wrap;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (!en || restart || wrap) cnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_timer.sv
// Wishbone down-counting timer: bus slave with one wait state, register file, expiry/irq logic.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] RELOAD_RST = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        irq
);
  logic                  pend_q, pend_d, ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic                  exp_q, exp_d;
  logic [31:0]           reload_q, reload_d, count_q, count_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;

  logic [ADR_W-1:0] idx;
  logic             req, xfer, wr, tick, expire, restart;
  logic             wr_ctrl, wr_status, wr_reload, wr_count, wr_presc;
  logic [31:0]      rdata;
  logic             unused_adr;

  assign idx        = wb_adr_i[ADR_LSB +: ADR_W];
  assign unused_adr = ^{wb_adr_i[31:ADR_LSB+ADR_W], wb_adr_i[ADR_LSB-1:0]};

  // A request must still be present on the second edge; that edge raises ack and commits.
  assign req  = wb_cyc_i & wb_stb_i;
  assign xfer = pend_q & req;
  assign wr   = xfer & wb_we_i;

  assign wr_ctrl   = wr && (idx == REG_CTRL);
  assign wr_status = wr && (idx == REG_STATUS);
  assign wr_reload = wr && (idx == REG_RELOAD);
  assign wr_count  = wr && (idx == REG_COUNT);
  assign wr_presc  = wr && (idx == REG_PRESCALE);

  assign expire  = tick && (count_q == '0);
  assign restart = wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_EN] & ~ctrl_q[CTRL_EN];

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq      = exp_q & ctrl_q[CTRL_IE];

  wb_timer_presc #(.W(PRESCALE_W)) u_presc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (ctrl_q[CTRL_EN]),
    .div       (presc_q),
    .restart   (restart),
    .tick      (tick)
  );

  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL:     rdata = 32'(ctrl_q);
      REG_STATUS:   rdata = 32'(exp_q) << STATUS_EXP;
      REG_RELOAD:   rdata = reload_q;
      REG_COUNT:    rdata = count_q;
      REG_PRESCALE: rdata = 32'(presc_q);
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    pend_d = req & ~ack_q & ~pend_q;
    ack_d  = xfer;
    dat_d  = (xfer && !wb_we_i) ? rdata : '0;

    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[CTRL_AR]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl && wb_sel_i[0])     ctrl_d = wb_dat_i[CTRL_W-1:0];

    // Expiry set beats a same-cycle write-1-to-clear
    exp_d = exp_q;
    if (wr_status && wb_sel_i[0] && wb_dat_i[STATUS_EXP]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;

    reload_d = wr_reload ? byte_merge(reload_q, wb_dat_i, wb_sel_i) : reload_q;
    presc_d  = wr_presc ? PRESCALE_W'(byte_merge(32'(presc_q), wb_dat_i, wb_sel_i)) : presc_q;

    count_d = count_q;
    if (tick) begin
      if (count_q == '0) count_d = ctrl_q[CTRL_AR] ? reload_q : '0;
      else               count_d = count_q - 32'd1;
    end
    if (wr_count) count_d = byte_merge(count_q, wb_dat_i, wb_sel_i);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ctrl_q   <= '0;
      exp_q    <= 1'b0;
      reload_q <= RELOAD_RST;
      count_q  <= RELOAD_RST;
      presc_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ctrl_q   <= ctrl_d;
      exp_q    <= exp_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
    end
  end
endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register vector table plus timed sequences for timer corner cases.
module tb_wb_timer;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic        wb_ack_o, irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  int          lat;

  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_RELD = 32'h08,
                          A_CNT  = 32'h0C, A_PRE  = 32'h10;

  always #5 sys_clk = ~sys_clk;

  wb_timer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .irq(irq)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat, output int cyc_n);
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    rdat = '0; cyc_n = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) begin cyc_n = i; rdat = wb_dat_o; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (cyc_n < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout adr=0x%08h", adr);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] r; int l;
    xfer(1'b1, adr, dat, 4'hF, r, l);
  endtask

  task automatic rdchk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r; int l;
    xfer(1'b0, adr, 32'h0, 4'hF, r, l);
    chk(name, r, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [31:0] cnt_exp [1:6];
    logic        ex_exp  [1:6];

    // reset state while held
    repeat (2) @(posedge sys_clk); #1;
    chk("rst_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    sys_rst_n = 1'b1;

    vecs.push_back('{"rd_ctrl0",   1'b0, A_CTRL, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_stat0",   1'b0, A_STAT, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_reld0",   1'b0, A_RELD, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_cnt0",    1'b0, A_CNT,  32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_pre0",    1'b0, A_PRE,  32'h0,         4'hF, 32'h0});
    vecs.push_back('{"wr_reld_be", 1'b1, A_RELD, 32'hAABBCCDD,  4'b0101, 32'h0});
    vecs.push_back('{"rd_reld_be", 1'b0, A_RELD, 32'h0,         4'hF, 32'h00BB00DD});
    vecs.push_back('{"wr_pre",     1'b1, A_PRE,  32'h12345678,  4'hF, 32'h0});
    vecs.push_back('{"rd_pre",     1'b0, A_PRE,  32'h0,         4'hF, 32'h00005678});
    vecs.push_back('{"wr_0x14",    1'b1, 32'h14, 32'hFFFFFFFF,  4'hF, 32'h0});
    vecs.push_back('{"rd_0x14",    1'b0, 32'h14, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_0x18",    1'b0, 32'h18, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_0x1c",    1'b0, 32'h1C, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"rd_ctrl_nc", 1'b0, A_CTRL, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"wr_ctrl6",   1'b1, A_CTRL, 32'hFFFFFFFE,  4'b0001, 32'h0});
    vecs.push_back('{"rd_ctrl6",   1'b0, A_CTRL, 32'h0,         4'hF, 32'h6});
    vecs.push_back('{"wr_ctrl_s0", 1'b1, A_CTRL, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{"rd_ctrl_s0", 1'b0, A_CTRL, 32'h0,         4'hF, 32'h6});
    vecs.push_back('{"wr_ctrl0",   1'b1, A_CTRL, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"wr_cnt_hi",  1'b1, A_CNT,  32'h12345678,  4'b1100, 32'h0});
    vecs.push_back('{"rd_cnt_hi",  1'b0, A_CNT,  32'h0,         4'hF, 32'h12340000});
    vecs.push_back('{"wr_pre0",    1'b1, A_PRE,  32'h0,         4'hF, 32'h0});
    vecs.push_back('{"wr_stat_w1", 1'b1, A_STAT, 32'h1,         4'hF, 32'h0});
    vecs.push_back('{"rd_stat_w1", 1'b0, A_STAT, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{"wr_ctrl5",   1'b1, A_CTRL, 32'h5,         4'hF, 32'h0});
    vecs.push_back('{"rd_ctrl5",   1'b0, A_CTRL, 32'h0,         4'hF, 32'h5});

    foreach (vecs[i]) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
      if (!vecs[i].we) chk(vecs[i].name, rd, vecs[i].exp);
      @(posedge sys_clk); #1;
      chk({vecs[i].name, "_ack1"}, 32'(wb_ack_o), 32'h0);
      chk({vecs[i].name, "_dat0"}, wb_dat_o, 32'h0);
    end

    // one-shot: expiry on the 4th tick after enable, EN self-clears
    wr(A_CTRL, 32'h0);
    wr(A_CNT, 32'h3);
    wr(A_CTRL, 32'h5);
    for (int k = 1; k <= 4; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("oneshot_irq_k%0d", k), 32'(irq), (k == 4) ? 32'h1 : 32'h0);
    end
    repeat (3) @(posedge sys_clk); #1;
    chk("oneshot_cnt_hold", dut.count_q, 32'h0);
    rdchk("oneshot_ctrl", A_CTRL, 32'h4);
    rdchk("oneshot_cnt", A_CNT, 32'h0);
    rdchk("oneshot_stat", A_STAT, 32'h1);
    wr(A_STAT, 32'h1);
    chk("w1c_irq", 32'(irq), 32'h0);

    // auto-reload with PRESCALE=2: tick every 3 cycles, expiry every 6
    wr(A_PRE, 32'h2);
    wr(A_RELD, 32'h1);
    wr(A_CNT, 32'h1);
    wr(A_CTRL, 32'h7);
    cnt_exp = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1};
    ex_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k <= 6; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("ar_cnt_k%0d", k), dut.count_q, cnt_exp[k]);
      chk($sformatf("ar_exp_k%0d", k), 32'(dut.exp_q), 32'(ex_exp[k]));
    end
    wr(A_STAT, 32'h1);
    chk("ar_cnt_k9", dut.count_q, 32'h0);
    chk("ar_exp_k9", 32'(dut.exp_q), 32'h0);
    repeat (2) @(posedge sys_clk); #1;
    chk("ar_exp_k11", 32'(dut.exp_q), 32'h0);
    @(posedge sys_clk); #1;
    chk("ar_cnt_k12", dut.count_q, 32'h1);
    chk("ar_exp_k12", 32'(dut.exp_q), 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);

    // COUNT write collides with a tick
    wr(A_PRE, 32'h0);
    wr(A_RELD, 32'h100);
    wr(A_CNT, 32'h50);
    wr(A_CTRL, 32'h3);
    wr(A_CNT, 32'h10);
    chk("coll_cnt_wr", dut.count_q, 32'h10);
    @(posedge sys_clk); #1;
    chk("coll_cnt_next", dut.count_q, 32'hF);
    wr(A_CTRL, 32'h0);

    // STATUS clear collides with an expiry
    wr(A_STAT, 32'h1);
    wr(A_CNT, 32'h2);
    wr(A_CTRL, 32'h3);
    wr(A_STAT, 32'h1);
    chk("coll_exp_set", 32'(dut.exp_q), 32'h1);
    chk("coll_reload", dut.count_q, 32'h100);
    rdchk("coll_stat_rd", A_STAT, 32'h1);

    // reset asserted during an ack cycle with irq high
    wr(A_CTRL, 32'h7);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_RELD; wb_sel_i = 4'hF;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk("pre_rst_ack", 32'(wb_ack_o), 32'h1);
    chk("pre_rst_dat", wb_dat_o, 32'h100);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_async_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_async_dat", wb_dat_o, 32'h0);
    chk("rst_async_irq", 32'(irq), 32'h0);
    chk("rst_async_cnt", dut.count_q, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // reset while a write is pending: no ack, no commit after release
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = A_CNT; wb_dat_i = 32'h77;
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(posedge sys_clk); #1; seen |= wb_ack_o; end
    chk("rst_abort_noack", 32'(seen), 32'h0);

    // strobe withdrawn after one edge: dropped
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = A_CNT; wb_dat_i = 32'h33;
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge sys_clk); #1; seen |= wb_ack_o; end
    chk("withdraw_noack", 32'(seen), 32'h0);

    rdchk("post_rst_cnt", A_CNT, 32'h0);
    rdchk("post_rst_ctrl", A_CTRL, 32'h0);
    rdchk("post_rst_stat", A_STAT, 32'h0);
    rdchk("post_rst_reld", A_RELD, 32'h0);
    rdchk("post_rst_pre", A_PRE, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, width of the prescaler divisor register and its counter.
REQ-002 SHALL have parameter RELOAD_RST, default 32'h0, reset value of RELOAD and COUNT.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port wb_adr_i, input, 32, byte address; only bits [4:2] are decoded.
REQ-006 SHALL have port wb_dat_i, input, 32, write data.
REQ-007 SHALL have port wb_dat_o, output, 32, read data.
REQ-008 SHALL have port wb_sel_i, input, 4, byte enables for writes.
REQ-009 SHALL have port wb_we_i, input, 1, write enable.
REQ-010 SHALL have port wb_cyc_i, input, 1, bus cycle, already qualified by the bus slave select.
REQ-011 SHALL have port wb_stb_i, input, 1, strobe.
REQ-012 SHALL have port wb_ack_o, output, 1, transfer acknowledge.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL implement the following register map. 0x00 CTRL: bit0 EN, bit1 AR (auto-reload), bit2 IE. 0x04 STATUS: bit0 EXP, sticky; writing 1 clears it. 0x08 RELOAD: 32 bits. 0x0C COUNT: 32 bits, read/write. 0x10 PRESCALE: PRESCALE_W bits.
REQ-015 SHALL handle offsets 0x14-0x1C as follows: reads return 0; writes are ignored; each access is still acked.
REQ-016 SHALL assert wb_ack_o for exactly one cycle, on the cycle after wb_cyc_i & wb_stb_i & ~wb_ack_o is sampled high, giving one wait state.
REQ-017 SHALL present wb_dat_o in the ack cycle, and drive 0 when not acking.
REQ-018 SHALL commit register writes on the acking edge only, byte-wise per wb_sel_i.
REQ-019 SHALL drop a cycle that wb_cyc_i or wb_stb_i withdraws before ack: no ack and no side effects.
REQ-020 SHALL generate the prescaler tick as follows: when EN=1, the prescaler counter counts 0..PRESCALE and emits a one-cycle tick on wrap. PRESCALE=0 gives a tick every cycle.
REQ-021 SHALL hold the prescaler counter at 0 while EN=0.
REQ-022 SHALL, on a tick with COUNT!=0, decrement COUNT by 1.
REQ-023 SHALL, on a tick with COUNT==0, set EXP. If AR=1, COUNT loads RELOAD. If AR=0, COUNT stays 0 and EN clears.
REQ-024 SHALL never let COUNT wrap below 0.
REQ-025 SHALL drive irq = EXP & IE combinationally from registers, with no added latency.
REQ-026 SHALL let a bus write to COUNT take priority over a same-cycle tick decrement or reload.
REQ-027 SHALL let a bus write to CTRL take priority over a same-cycle auto-clear of EN.
REQ-028 SHALL let an expiry set EXP even when a write-1-to-clear hits STATUS in the same cycle (set wins).
REQ-029 SHALL NOT alter COUNT when RELOAD is written; RELOAD takes effect at the next expiry.
REQ-030 SHALL, when EN is written 0->1, restart the prescaler from 0 and leave COUNT unchanged.

Reset
REQ-031 SHALL, while sys_rst_n=0, force the following values asynchronously: wb_ack_o=0, wb_dat_o=0, irq=0, CTRL=0, EXP=0, PRESCALE=0, prescaler counter=0, RELOAD=RELOAD_RST, COUNT=RELOAD_RST.
REQ-032 SHALL, when reset asserts mid-transfer, abort the transfer with no ack after release; the master re-issues it.
REQ-033 SHALL treat reset deassertion as synchronous to sys_clk (an external synchronizer provides this), and resume operation on the first rising edge after release.

Structure
REQ-034 SHALL take register offsets, CTRL/STATUS bit positions and the decode width from a shared package, wb_timer_pkg, also used by firmware header generation.
REQ-035 SHALL contain one sub-module, wb_timer_presc, holding the prescaler counter and tick generation, with inputs en, div and restart and output tick.
REQ-036 SHALL keep the bus decode and register file in the top level, with no combinational path from wb_* inputs to wb_ack_o.

Verification
REQ-037 SHALL verify this bus timing: write CTRL=0x5 -> wb_ack_o high exactly 1 cycle, 2 cycles after stb; read back 0x5 with dat valid in the ack cycle.
REQ-038 SHALL verify one-shot mode: PRESCALE=0, COUNT=3, CTRL=0x5 -> EXP and irq set on the 4th cycle after enable; EN reads 0; COUNT stays 0.
REQ-039 SHALL verify auto-reload: PRESCALE=2, RELOAD=1, COUNT=1, CTRL=0x7 -> EXP sets every 6 cycles; COUNT sequence 1,0,1,0.
REQ-040 SHALL verify collisions: a COUNT write of 0x10 on a tick cycle -> COUNT=0x10, not decremented; a STATUS write of 1 on an expiry cycle -> EXP remains 1.
REQ-041 SHALL verify byte enables: write 0xAABBCCDD to RELOAD with sel=4'b0101 -> RELOAD=0x00BB00DD from reset value 0.
REQ-042 SHALL verify reset and abort: assert sys_rst_n low mid-count -> all outputs 0 immediately, COUNT=RELOAD_RST; a stb withdrawn before ack -> no ack and no register change.
